// File: rtl/fx_arith_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks: default widths,
// the root-engine state encoding and a helper for the total word width.
package fx_arith_pkg;

  localparam int unsigned DEF_INT_W  = 10;
  localparam int unsigned DEF_FRAC_W = 10;
  localparam int unsigned DEF_EXP_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_MUL  = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } fx_state_t;

  // Total word width of a Q(int_w.frac_w) value.
  function automatic int unsigned fx_total_w(input int unsigned int_w,
                                             input int unsigned frac_w);
    return int_w + frac_w;
  endfunction

endpackage

// File: rtl/fx_mul_trunc.sv
// Combinational Q-format multiply: y = (a*b) >> FRAC_W truncated to W bits,
// ovf flags any bit of the shifted product that does not fit in W bits.
module fx_mul_trunc
  import fx_arith_pkg::*;
#(
  parameter int unsigned W      = fx_total_w(DEF_INT_W, DEF_FRAC_W),
  parameter int unsigned FRAC_W = DEF_FRAC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);

  logic [2*W-1:0] prod;

  // Full-width product, then take the W-bit window above the fraction bits.
  always_comb begin
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    y    = prod[W+FRAC_W-1:FRAC_W];
    ovf  = |prod[2*W-1:W+FRAC_W];
  end

endmodule

// File: rtl/nth_root_fx_pipe.sv
// Bit-serial n-th root engine. Builds the root MSB first: each candidate bit
// is raised to the n-th power by repeated truncating multiplies and kept if
// the power does not exceed N<<FRAC_W and never overflowed.
module nth_root_fx_pipe
  import fx_arith_pkg::*;
#(
  parameter int unsigned INT_W  = DEF_INT_W,
  parameter int unsigned FRAC_W = DEF_FRAC_W,
  parameter int unsigned EXP_W  = DEF_EXP_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INT_W-1:0]          in_radicand,
  input  logic [EXP_W-1:0]          in_exp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INT_W+FRAC_W-1:0]   out_data,
  output logic                      out_exact,
  output logic                      out_err
);

  localparam int unsigned W  = fx_total_w(INT_W, FRAC_W);
  localparam int unsigned KW = $clog2(W);

  fx_state_t        state;
  logic [EXP_W-1:0] n_q;
  logic [EXP_W-1:0] cnt;
  logic [KW-1:0]    k;
  logic [W-1:0]     t_q;
  logic [W-1:0]     res;
  logic [W-1:0]     acc;
  logic             ovf;

  logic [W-1:0]     cand;
  logic [W-1:0]     mul_y;
  logic             mul_ovf;
  logic             accept;
  logic [W-1:0]     res_nx;
  logic [KW-1:0]    k_dn;

  fx_mul_trunc #(
    .W      (W),
    .FRAC_W (FRAC_W)
  ) u_mul (
    .a   (acc),
    .b   (cand),
    .y   (mul_y),
    .ovf (mul_ovf)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Candidate for the current bit and the comparison outcome used in CMP.
  always_comb begin
    cand   = res | (W'(1) << k);
    accept = !ovf && (acc <= t_q);
    res_nx = accept ? cand : res;
    k_dn   = k - KW'(1);
  end

  // Main FSM: operand capture, per-bit power/compare loop, result hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      n_q       <= '0;
      cnt       <= '0;
      k         <= '0;
      t_q       <= '0;
      res       <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_data  <= '0;
      out_exact <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            n_q       <= in_exp;
            t_q       <= {in_radicand, {FRAC_W{1'b0}}};
            out_data  <= '0;
            out_exact <= 1'b0;
            out_err   <= 1'b0;
            if (in_exp == '0) begin
              out_err <= 1'b1;
              state   <= ST_DONE;
            end else if (in_exp == EXP_W'(1)) begin
              out_data  <= {in_radicand, {FRAC_W{1'b0}}};
              out_exact <= 1'b1;
              state     <= ST_DONE;
            end else if (in_radicand == '0) begin
              out_exact <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_INIT;
            end
          end
        end
        ST_INIT: begin
          res   <= '0;
          k     <= KW'(W-1);
          acc   <= W'(1) << (W-1);
          ovf   <= 1'b0;
          cnt   <= EXP_W'(1);
          state <= ST_MUL;
        end
        ST_MUL: begin
          acc <= mul_y;
          ovf <= ovf | mul_ovf;
          cnt <= cnt + EXP_W'(1);
          if (cnt + EXP_W'(1) == n_q)
            state <= ST_CMP;
        end
        ST_CMP: begin
          res <= res_nx;
          if (accept && (acc == t_q)) begin
            out_data  <= cand;
            out_exact <= 1'b1;
            state     <= ST_DONE;
          end else if (k == '0) begin
            out_data <= res_nx;
            state    <= ST_DONE;
          end else begin
            // Next candidate is seeded here so MUL starts multiplying at once.
            k     <= k_dn;
            acc   <= res_nx | (W'(1) << k_dn);
            ovf   <= 1'b0;
            cnt   <= EXP_W'(1);
            state <= ST_MUL;
          end
        end
        ST_DONE: begin
          if (out_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nth_root_fx_pipe.sv
// Self-checking bench for nth_root_fx_pipe: directed cases plus random
// operands compared against a behavioural model of the truncating root.
module tb_nth_root_fx_pipe;

  localparam int unsigned IW = 10;
  localparam int unsigned FW = 10;
  localparam int unsigned EW = 3;
  localparam int unsigned W  = IW + FW;

  typedef struct {
    longint unsigned data;
    bit              exact;
    bit              err;
    int              lat;
  } model_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_radicand;
  logic [EW-1:0] in_exp;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_exact;
  logic          out_err;

  int err_cnt = 0;
  int chk_cnt = 0;

  nth_root_fx_pipe #(
    .INT_W  (IW),
    .FRAC_W (FW),
    .EXP_W  (EW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_radicand (in_radicand),
    .in_exp      (in_exp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_exact   (out_exact),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint unsigned got,
                          input longint unsigned exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Root built MSB first with the truncating power iteration.
  function automatic model_t ref_root(input int unsigned nr, input int unsigned ne);
    model_t          m;
    longint unsigned t, res, c, p, lim;
    bit              ovf;
    int              bits;
    m.data = 0; m.exact = 0; m.err = 0; m.lat = 1;
    if (ne == 0) begin m.err = 1; return m; end
    if (ne == 1) begin m.data = longint'(nr) << FW; m.exact = 1; return m; end
    if (nr == 0) begin m.exact = 1; return m; end
    t    = longint'(nr) << FW;
    lim  = 64'd1 << W;
    res  = 0;
    bits = 0;
    for (int kk = W - 1; kk >= 0; kk--) begin
      bits++;
      c   = res | (64'd1 << kk);
      p   = c;
      ovf = 0;
      for (int i = 1; i < int'(ne); i++) begin
        p = (p * c) >> FW;
        if (p >= lim) ovf = 1;
        p = p % lim;
      end
      if (!ovf && p <= t) begin
        res = c;
        if (p == t) begin m.exact = 1; break; end
      end
    end
    m.data = res;
    m.lat  = 2 + int'(ne) * bits;
    return m;
  endfunction

  // One transaction: present operand, wait for result, optional backpressure.
  task automatic run_job(input string tag, input int unsigned nr, input int unsigned ne,
                         input model_t exp, input int hold);
    int lat;
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_radicand = IW'(nr);
    in_exp      = EW'(ne);
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_lat"},   64'(lat),       64'(exp.lat));
    check_eq({tag, "_data"},  64'(out_data),  exp.data);
    check_eq({tag, "_exact"}, 64'(out_exact), 64'(exp.exact));
    check_eq({tag, "_err"},   64'(out_err),   64'(exp.err));
    for (int h = 0; h < hold; h++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_radicand = IW'($urandom);
      in_exp      = EW'($urandom);
      @(posedge clk); #1;
      check_eq({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, "_hold_data"},  64'(out_data),  exp.data);
      check_eq({tag, "_hold_exact"}, 64'(out_exact), 64'(exp.exact));
      check_eq({tag, "_hold_err"},   64'(out_err),   64'(exp.err));
      check_eq({tag, "_hold_rdy"},   64'(in_ready),  64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_rel_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_rel_rdy"},   64'(in_ready),  64'd1);
  endtask

  function automatic model_t mk(input longint unsigned d, input bit e, input bit r,
                                input int l);
    model_t m;
    m.data = d; m.exact = e; m.err = r; m.lat = l;
    return m;
  endfunction

  initial begin
    int unsigned nr, ne;
    int          stray;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_radicand = '0;
    in_exp      = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  64'(in_ready),  64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data",  64'(out_data),  64'd0);
    check_eq("rst_out_exact", 64'(out_exact), 64'd0);
    check_eq("rst_out_err",   64'(out_err),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with hand-derived expectations.
    run_job("cube27", 27, 3, mk(64'd3072, 1'b1, 1'b0, 32), 0);
    run_job("sqrt2",  2,  2, mk(64'd1448, 1'b0, 1'b0, 42), 0);
    run_job("n1",     1023, 1, mk(64'hFFC00, 1'b1, 1'b0, 1), 0);
    run_job("n0",     1023, 0, mk(64'd0, 1'b0, 1'b1, 1), 0);
    run_job("zero",   0, 5, mk(64'd0, 1'b1, 1'b0, 1), 0);
    run_job("ovf7",   1000, 7, ref_root(1000, 7), 0);
    run_job("bp",     500, 3, ref_root(500, 3), 5);

    // Reset in the middle of a MUL phase; the aborted job must never emit.
    in_radicand = IW'(1000);
    in_exp      = EW'(7);
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort_valid", 64'(out_valid), 64'd0);
    check_eq("abort_rdy",   64'(in_ready),  64'd1);
    check_eq("abort_data",  64'(out_data),  64'd0);
    rst_n = 1'b1;
    stray = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    check_eq("abort_stray", 64'(stray), 64'd0);
    run_job("after_rst", 16, 4, mk(64'd2048, 1'b1, 1'b0, 38), 0);

    // Random operands against the model, occasional backpressure.
    for (int r = 0; r < 25; r++) begin
      nr = $urandom_range(0, 1023);
      ne = $urandom_range(0, 7);
      run_job("rand", nr, ne, ref_root(nr, ne), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
